spi_slave_word: RTL and testbench
=================================

Name: spi_slave_word

Overview:
Parametrised successor to the team's 8-bit SPI slave.
- Configurable word width and bit order.
- Back-to-back multi-word frames within one chip-select assertion; per-word TX-consumed and RX-valid pulses and a frame word counter.
- Entirely in the sclk domain; the parent handles any crossing into the system clock domain.

Parameters:
WIDTH, 8, bits per word; must be >= 2.
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO, 0 = LSB first.
WCNT_W, 8, width of the frame word counter.
CNT_W, $clog2(WIDTH), localparam, bit counter width.

Ports:
sclk  in  1  SPI clock; mode 0 (idle low, sample on rising edge).
rst  in  1  reset, asynchronous, active-high.
cs_n  in  1  chip select, active-low; high = deselected (asynchronous clear, see Behaviour).
mosi  in  1  serial data in.
miso  out  1  serial data out (combinational from TX state).
tx_data  in  WIDTH  next word to transmit; must be stable while bit_cnt==0 and cs_n low.
tx_ack  out  1  pulse: tx_data consumed this word.
rx_data  out  WIDTH  last complete received word (holding register).
rx_valid  out  1  pulse: rx_data updated.
word_cnt  out  WCNT_W  complete words received in the current frame.
busy  out  1  mid-word (cs_n low and bit_cnt != 0).

Behaviour:
- Reset (rst high, async): bit_cnt=0, tx_sh=0, rx_sh=0, rx_data=0, rx_valid=0, tx_ack=0, word_cnt=0.
  - miso then reflects the first bit of tx_data; busy=0.
- cs_n high (async clear, rst has priority): bit_cnt=0, rx_valid=0, tx_ack=0, word_cnt=0.
  - rx_data retained; tx_sh/rx_sh don't-care.
- First-bit selector F = WIDTH-1 if MSB_FIRST else 0.
- miso = tx_data[F] when bit_cnt==0, else tx_sh[F].
  - Changes only after a rising sclk edge or a tx_data change at bit_cnt==0; master samples on the next rising edge.
- Rising sclk with cs_n low:
  - rx_sh shifts in mosi toward the far end (left shift if MSB_FIRST, right shift otherwise).
  - bit_cnt==0: tx_sh <= tx_data shifted by one position (zero fill); tx_ack <= 1. Otherwise tx_sh shifts by one (zero fill) and tx_ack <= 0.
  - bit_cnt==WIDTH-1 (word complete):
    - rx_data <= assembled word including the current mosi bit; rx_valid <= 1.
    - bit_cnt <= 0; word_cnt <= word_cnt+1, saturating at all-ones.
  - Otherwise: bit_cnt <= bit_cnt+1; rx_valid <= 0.
- Pulses (tx_ack, rx_valid) are high for exactly one sclk period, from one rising edge to the next, or until cs_n rises.
- Back-to-back words: the edge completing word N is immediately followed by bit 0 of word N+1.
  - No gap cycle.
  - tx_data is re-read at bit_cnt==0 of every word.
- cs_n rising mid-word: partial word discarded; rx_data keeps the last complete word; no rx_valid.
- sclk edges while cs_n high have no effect (held in clear).
- Latency: rx_data valid one clock-to-q after the WIDTH-th rising edge of a word.

Optional Feature:
Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit) and a process clocked on posedge cs_n (async reset rst).
  - On each cs_n rise, frame_err <= (bit_cnt != 0), i.e. deselect mid-word.
  - Sticky until the next cs_n rise with bit_cnt==0, or until rst.
- Undefined: port and logic absent; partial words silently dropped.

Decomposition:
- Shared package spi_pkg: mode constants (SPI_MODE0), first-bit index function first_bit(WIDTH, MSB_FIRST), default widths.
- One natural sub-module spi_shift_reg: a bidirectional shift register with parameters WIDTH and MSB_FIRST, with parallel load, serial in, and first-bit out. It is instantiated twice, for TX and RX.
- Counter and pulse logic stay in the top.

Test Plan:
- Reset: assert rst mid-word with WIDTH=8 -> all outputs 0 immediately; miso = tx_data[7]; after release, the next 8-bit frame is received correctly.
- Single word: WIDTH=8, MSB_FIRST=1, tx_data=0xA5, master sends 0x3C -> MISO stream 1,0,1,0,0,1,0,1; tx_ack high after edge 1; rx_data=0x3C with rx_valid pulse after edge 8; word_cnt=1.
- Back-to-back: three words 0x01, 0x80, 0xFF under one cs_n low; tx_data changed at each tx_ack -> three rx_valid pulses with the correct words; word_cnt 3; no gap cycle.
- LSB first: WIDTH=16, MSB_FIRST=0, tx_data=0x8001, master sends 0x1234 LSB-first -> miso bit0 first (1), then 0s, last bit 1; rx_data=0x1234 after 16 edges.
- Abort: cs_n rises after 5 of 8 edges -> rx_data keeps the previous word; no rx_valid; word_cnt=0, bit_cnt=0; with SPI_SLAVE_FRAME_ERR_EN, frame_err=1 until the next clean frame ends.
- Saturation: WCNT_W=2, five words in one frame -> word_cnt sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, default widths, first-bit helper.
package spi_pkg;
  localparam logic [1:0] SPI_MODE0  = 2'b00;
  localparam int         DEF_WIDTH  = 8;
  localparam int         DEF_WCNT_W = 8;

  // Bit position that leaves the shifter first.
  function automatic int first_bit(input int width, input bit msb_first);
    return msb_first ? width - 1 : 0;
  endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// Bidirectional shift register: optional parallel load merged with a one-bit shift,
// serial in at the far end, first bit out.
module spi_shift_reg import spi_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] nxt,
  output logic             sout
);
  localparam int F = first_bit(WIDTH, MSB_FIRST);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] base;

  // Load and shift happen in the same edge: the loaded word's first bit is already on the wire.
  always_comb begin
    base = load ? din : sh;
    if (MSB_FIRST) nxt = {base[WIDTH-2:0], sin};
    else           nxt = {sin, base[WIDTH-1:1]};
  end

  always_ff @(posedge sclk or posedge rst)
    if (rst)     sh <= '0;
    else if (en) sh <= nxt;

  assign sout = sh[F];
endmodule

// File: rtl/spi_slave_word.sv
// Mode-0 SPI slave with configurable word width/bit order and multi-word frames.
// Optional deselect-mid-word flag enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_word import spi_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int WCNT_W    = DEF_WCNT_W
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [WIDTH-1:0]  tx_data,
  output logic              tx_ack,
  output logic [WIDTH-1:0]  rx_data,
  output logic              rx_valid,
  output logic [WCNT_W-1:0] word_cnt,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam bit MSB   = (MSB_FIRST != 0);
  localparam int F     = first_bit(WIDTH, MSB);

  logic [CNT_W-1:0] bit_cnt;
  logic             active, first, last;
  logic [WIDTH-1:0] rx_nxt, unused_tx_nxt;
  logic             tx_sout, unused_rx_sout;

  assign active = !cs_n;
  assign first  = (bit_cnt == '0);
  assign last   = (bit_cnt == CNT_W'(WIDTH - 1));

  spi_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB)) u_tx (
    .sclk(sclk), .rst(rst), .en(active), .load(first), .din(tx_data), .sin(1'b0),
    .nxt(unused_tx_nxt), .sout(tx_sout)
  );

  spi_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB)) u_rx (
    .sclk(sclk), .rst(rst), .en(active), .load(1'b0), .din('0), .sin(mosi),
    .nxt(rx_nxt), .sout(unused_rx_sout)
  );

  // Before the first edge of a word the shifter has not loaded yet, so drive straight from tx_data.
  assign miso = first ? tx_data[F] : tx_sout;
  assign busy = active && !first;

  always_ff @(posedge sclk or posedge rst or posedge cs_n)
    if (rst) begin
      bit_cnt  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      word_cnt <= '0;
    end else if (cs_n) begin
      bit_cnt  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      word_cnt <= '0;
    end else begin
      tx_ack <= first;
      if (last) begin
        bit_cnt  <= '0;
        rx_valid <= 1'b1;
        if (word_cnt != '1) word_cnt <= word_cnt + WCNT_W'(1);
      end else begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        rx_valid <= 1'b0;
      end
    end

  // Holding register survives deselect; only a completed word replaces it.
  always_ff @(posedge sclk or posedge rst)
    if (rst)                 rx_data <= '0;
    else if (active && last) rx_data <= rx_nxt;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Samples bit_cnt before the same cs_n edge clears it.
  always_ff @(posedge cs_n or posedge rst)
    if (rst) frame_err <= 1'b0;
    else     frame_err <= !first;
`endif
endmodule

// File: tb/tb_spi_slave_word.sv
// Scoreboard bench for spi_slave_word: DUT A (8b MSB-first, 2b word counter), DUT B (16b LSB-first).
module tb_spi_slave_word;
  logic        sclk = 0, rst = 1, mosi = 0, cs_a = 1, cs_b = 1;
  logic [7:0]  txd_a = 8'hC3;
  logic [15:0] txd_b = 16'h0001;
  logic        miso_a, miso_b, ack_a, ack_b, rv_a, rv_b, busy_a, busy_b;
  logic [7:0]  rxd_a;
  logic [15:0] rxd_b;
  logic [1:0]  wc_o_a;
  logic [7:0]  wc_o_b;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        fe_o_a, fe_o_b;
`endif

  spi_slave_word #(.WIDTH(8), .MSB_FIRST(1), .WCNT_W(2)) dut_a (
    .sclk(sclk), .rst(rst), .cs_n(cs_a), .mosi(mosi), .miso(miso_a), .tx_data(txd_a),
    .tx_ack(ack_a), .rx_data(rxd_a), .rx_valid(rv_a), .word_cnt(wc_o_a),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err(fe_o_a),
`endif
    .busy(busy_a));

  spi_slave_word #(.WIDTH(16), .MSB_FIRST(0), .WCNT_W(8)) dut_b (
    .sclk(sclk), .rst(rst), .cs_n(cs_b), .mosi(mosi), .miso(miso_b), .tx_data(txd_b),
    .tx_ack(ack_b), .rx_data(rxd_b), .rx_valid(rv_b), .word_cnt(wc_o_b),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err(fe_o_b),
`endif
    .busy(busy_b));

  typedef struct { logic [15:0] data; int wcnt; } exp_t;
  exp_t sb_a[$], sb_b[$];

  int checks = 0, errors = 0;
  int wc_a = 0, wc_b = 0;
  logic [15:0] last_a = 0, last_b = 0;
  bit fe_a = 0, fe_b = 0;
  logic [15:0] tw[8], rw[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every rx_valid seen must match the oldest expected word.
  always @(negedge sclk) begin
    exp_t e;
    if (rv_a) begin
      if (sb_a.size() == 0) chk("sb_a_unexpected_rx", 1, 0);
      else begin
        e = sb_a.pop_front();
        chk("sb_a_rx_data", {24'h0, rxd_a}, {16'h0, e.data});
        chk("sb_a_word_cnt", {30'h0, wc_o_a}, e.wcnt);
      end
    end
    if (rv_b) begin
      if (sb_b.size() == 0) chk("sb_b_unexpected_rx", 1, 0);
      else begin
        e = sb_b.pop_front();
        chk("sb_b_rx_data", {16'h0, rxd_b}, {16'h0, e.data});
        chk("sb_b_word_cnt", {24'h0, wc_o_b}, e.wcnt);
      end
    end
  end

  // Shift nb bits of one word; a full word (nb == W) is expected to complete.
  task automatic send_word(input int sel, input logic [15:0] txw, input logic [15:0] rxw, input int nb);
    int W   = sel ? 16 : 8;
    bit msb = (sel == 0);
    int sat = sel ? 255 : 3;
    int wc  = sel ? wc_b : wc_a;
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      int idx = msb ? W - 1 - i : i;
      mosi = rxw[idx];
      if (i == 0) begin
        if (sel) txd_b = txw; else txd_a = txw[7:0];
      end
      #2 chk("miso", {31'h0, sel ? miso_b : miso_a}, {31'h0, txw[idx]});
      if (i == W - 1) begin
        wc = (wc < sat) ? wc + 1 : sat;
        e.data = sel ? rxw : {8'h0, rxw[7:0]};
        e.wcnt = wc;
        if (sel) begin sb_b.push_back(e); last_b = rxw; end
        else     begin sb_a.push_back(e); last_a = {8'h0, rxw[7:0]}; end
      end
      #3 sclk = 1;
      #5 sclk = 0;
      chk("tx_ack",   {31'h0, sel ? ack_b : ack_a},   {31'h0, i == 0});
      chk("rx_valid", {31'h0, sel ? rv_b : rv_a},     {31'h0, i == W - 1});
      chk("busy",     {31'h0, sel ? busy_b : busy_a}, {31'h0, i != W - 1});
      chk("word_cnt", sel ? {24'h0, wc_o_b} : {30'h0, wc_o_a}, wc);
      // tx_data is only consumed at the word start; garbage mid-word must not reach miso.
      if (i == 0) begin
        if (sel) txd_b = 16'($urandom); else txd_a = 8'($urandom);
      end
    end
    if (sel) wc_b = wc; else wc_a = wc;
  endtask

  task automatic frame(input int sel, input int n, input bit abort);
    int W = sel ? 16 : 8;
    if (sel) cs_b = 0; else cs_a = 0;
    #5;
    for (int w = 0; w < n; w++) send_word(sel, tw[w], rw[w], W);
    if (abort) send_word(sel, 16'($urandom), 16'($urandom), $urandom_range(1, W - 1));
    #2;
    if (sel) begin cs_b = 1; wc_b = 0; fe_b = abort; end
    else     begin cs_a = 1; wc_a = 0; fe_a = abort; end
    #3;
    chk("end_word_cnt", sel ? {24'h0, wc_o_b} : {30'h0, wc_o_a}, 0);
    chk("end_busy",     {31'h0, sel ? busy_b : busy_a}, 0);
    chk("end_rx_valid", {31'h0, sel ? rv_b : rv_a}, 0);
    chk("end_tx_ack",   {31'h0, sel ? ack_b : ack_a}, 0);
    chk("end_rx_data",  sel ? {16'h0, rxd_b} : {24'h0, rxd_a}, sel ? {16'h0, last_b} : {16'h0, last_a});
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("frame_err", {31'h0, sel ? fe_o_b : fe_o_a}, {31'h0, sel ? fe_b : fe_a});
`endif
    #5;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_rx_data_a", {24'h0, rxd_a}, 0);
    chk("rst_rx_data_b", {16'h0, rxd_b}, 0);
    chk("rst_flags_a", {28'h0, rv_a, ack_a, busy_a, 1'b0}, 0);
    chk("rst_word_cnt_a", {30'h0, wc_o_a}, 0);
    chk("rst_miso_a", {31'h0, miso_a}, 1);
    chk("rst_miso_b", {31'h0, miso_b}, 1);
    #7 rst = 0;
    #10;

    // Single word, MSB first
    tw[0] = 16'h00A5; rw[0] = 16'h003C;
    frame(0, 1, 0);

    // Back-to-back three words
    rw[0] = 16'h0001; rw[1] = 16'h0080; rw[2] = 16'h00FF;
    for (int k = 0; k < 3; k++) tw[k] = 16'($urandom);
    frame(0, 3, 0);

    // LSB first, 16 bits
    tw[0] = 16'h8001; rw[0] = 16'h1234;
    frame(1, 1, 0);

    // Abort after 5 bits, then a clean frame clears the error flag
    tw[0] = 16'h005A; rw[0] = 16'h00C7;
    frame(0, 1, 0);
    cs_a = 0; #5;
    send_word(0, 16'h00FF, 16'h0013, 5);
    #2 cs_a = 1; wc_a = 0; fe_a = 1; #3;
    chk("abort_rx_data", {24'h0, rxd_a}, {16'h0, last_a});
    chk("abort_word_cnt", {30'h0, wc_o_a}, 0);
    chk("abort_busy", {31'h0, busy_a}, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_frame_err", {31'h0, fe_o_a}, 1);
`endif
    #5;
    tw[0] = 16'h0011; rw[0] = 16'h0022;
    frame(0, 1, 0);

    // Word counter saturation on the 2-bit counter
    for (int k = 0; k < 5; k++) begin tw[k] = 16'($urandom); rw[k] = 16'($urandom); end
    frame(0, 5, 0);

    // Reset asserted mid-word
    cs_a = 0; #5;
    send_word(0, 16'h00B6, 16'h0055, 3);
    #2 rst = 1; #1;
    chk("midrst_rx_data", {24'h0, rxd_a}, 0);
    chk("midrst_flags", {28'h0, rv_a, ack_a, busy_a, 1'b0}, 0);
    chk("midrst_word_cnt", {30'h0, wc_o_a}, 0);
    chk("midrst_miso", {31'h0, miso_a}, {31'h0, txd_a[7]});
    #2 cs_a = 1; #5 rst = 0;
    wc_a = 0; wc_b = 0; last_a = 0; last_b = 0; fe_a = 0; fe_b = 0;
    #5;
    tw[0] = 16'h00E1; rw[0] = 16'h009D;
    frame(0, 1, 0);

    // Randomized frames on both configurations
    for (int f = 0; f < 24; f++) begin
      int sel = $urandom_range(0, 1);
      int n   = $urandom_range(1, 5);
      bit ab  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < n; k++) begin tw[k] = 16'($urandom); rw[k] = 16'($urandom); end
      frame(sel, n, ab);
    end

    #10;
    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
